// File: rtl/peg_l2_rs_xmii_tx_if.sv
// Packet-transfer stream from the L2 MAC into the xMII transmit reconciliation block.
// Signals:
//   pkt_valid  source word valid
//   pkt_sop    first word of packet
//   pkt_eop    last word of packet
//   pkt_bytes  valid bytes in the eop word, 0 = all bytes
//   pkt_data   packet data, byte 0 in [7:0]
//   pkt_ready  word accepted when pkt_valid & pkt_ready
// Modports: master = packet source, slave = reconciliation block.
interface peg_l2_rs_xmii_tx_if #(
   parameter int unsigned PKT_DATA_W = 64
) ();
   localparam int unsigned BYTES_W = $clog2(PKT_DATA_W / 8);

   logic                  pkt_valid;
   logic                  pkt_sop;
   logic                  pkt_eop;
   logic [BYTES_W-1:0]    pkt_bytes;
   logic [PKT_DATA_W-1:0] pkt_data;
   logic                  pkt_ready;

   modport master (
      output pkt_valid, pkt_sop, pkt_eop, pkt_bytes, pkt_data,
      input  pkt_ready
   );

   modport slave (
      input  pkt_valid, pkt_sop, pkt_eop, pkt_bytes, pkt_data,
      output pkt_ready
   );
endinterface

// File: rtl/peg_l2_rs_xmii_tx.sv
// MII-family transmit reconciliation: serialises L2 packet words onto a 2/4/8-bit line,
// inserting preamble + SFD, pacing symbols for 10/100, enforcing an IFG and flagging underrun.
// Ports:
//   clk, rst            reference clock, synchronous active-high reset
//   cfg_speed_100_n_10  1 = symbol every cycle, 0 = symbol every SLOW_DIV cycles
//   pkt                 packet stream (slave side); pkt_ready is combinational
//   txd, tx_en, tx_er   registered line outputs, LSB-first within each byte
//   stat_pkt_done       pulse coincident with the last data symbol of a packet
//   stat_underrun       pulse coincident with the tx_er symbol
module peg_l2_rs_xmii_tx #(
   parameter int unsigned PKT_DATA_W = 64,
   parameter int unsigned MII_DATA_W = 2,
   parameter int unsigned IFG_BYTES  = 12,
   parameter int unsigned SLOW_DIV   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_speed_100_n_10,
   peg_l2_rs_xmii_tx_if.slave    pkt,
   output logic [MII_DATA_W-1:0] txd,
   output logic                  tx_en,
   output logic                  tx_er,
   output logic                  stat_pkt_done,
   output logic                  stat_underrun
);
   localparam int unsigned SPB      = 8 / MII_DATA_W;
   localparam int unsigned SPW      = PKT_DATA_W / MII_DATA_W;
   localparam int unsigned PRE_SYMS = 8 * SPB;
   localparam int unsigned IDX_MAX  = (SPW > PRE_SYMS) ? SPW : PRE_SYMS;
   localparam int unsigned IDX_W    = $clog2(IDX_MAX);
   localparam int unsigned BYTES_W  = $clog2(PKT_DATA_W / 8);
   localparam int unsigned DIV_W    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int unsigned IFG_W    = $clog2(IFG_BYTES * SPB + 1);

   localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_SYMS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
   localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_BYTES * SPB - 1);
   // Seven 0x55 bytes then the 0xD5 SFD, byte 0 first.
   localparam logic [63:0]      PRE_WORD = 64'hD555_5555_5555_5555;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_DROP = 3'd3;
   localparam logic [2:0] S_IFG  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IFG_W-1:0]      ifg_q, ifg_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  speed_q, speed_d;
   logic                  err_q, err_d;
   logic [PKT_DATA_W-1:0] buf_data_q, buf_data_d;
   logic                  buf_eop_q, buf_eop_d;
   logic [BYTES_W-1:0]    buf_bytes_q, buf_bytes_d;
   logic [MII_DATA_W-1:0] txd_q, txd_d;
   logic                  tx_en_q, tx_en_d;
   logic                  tx_er_q, tx_er_d;
   logic                  stat_pkt_done_q, stat_pkt_done_d;
   logic                  stat_underrun_q, stat_underrun_d;
   logic                  strobe_c;
   logic                  ready_c;
   logic [IDX_W-1:0]      last_c;

   // Index of the final symbol to send from a buffered word.
   function automatic logic [IDX_W-1:0] last_sym(input logic eop, input logic [BYTES_W-1:0] nb);
      if (eop && (nb != '0)) last_sym = IDX_W'(32'(nb) * SPB - 1);
      else                   last_sym = IDX_W'(SPW - 1);
   endfunction

   assign strobe_c      = speed_q | (div_q == DIV_LAST);
   assign last_c        = last_sym(buf_eop_q, buf_eop_q ? buf_bytes_q : '0);
   assign pkt.pkt_ready = ready_c & ~rst;

   // Next-state, buffer, counters and next registered outputs.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      ifg_d           = ifg_q;
      speed_d         = speed_q;
      err_d           = err_q;
      buf_data_d      = buf_data_q;
      buf_eop_d       = buf_eop_q;
      buf_bytes_d     = buf_bytes_q;
      ready_c         = 1'b0;
      stat_underrun_d = 1'b0;
      txd_d           = '0;
      tx_en_d         = 1'b0;
      tx_er_d         = 1'b0;

      if (state_q == S_IDLE || div_q == DIV_LAST) div_d = '0;
      else                                        div_d = div_q + DIV_W'(1);

      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            idx_d   = '0;
            err_d   = 1'b0;
            if (pkt.pkt_valid && pkt.pkt_sop) begin
               buf_data_d  = pkt.pkt_data;
               buf_eop_d   = pkt.pkt_eop;
               buf_bytes_d = pkt.pkt_bytes;
               speed_d     = cfg_speed_100_n_10;
               state_d     = S_PRE;
            end
         end
         S_PRE: begin
            if (strobe_c) begin
               if (idx_q == PRE_LAST) begin
                  idx_d   = '0;
                  state_d = S_DATA;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_DATA: begin
            if (strobe_c) begin
               if (idx_q != last_c) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (buf_eop_q) begin
                  ifg_d   = IFG_LOAD;
                  state_d = S_IFG;
               end else begin
                  ready_c = 1'b1;
                  if (pkt.pkt_valid) begin
                     buf_data_d  = pkt.pkt_data;
                     buf_eop_d   = pkt.pkt_eop;
                     buf_bytes_d = pkt.pkt_bytes;
                     idx_d       = '0;
                  end else begin
                     err_d           = 1'b1;
                     stat_underrun_d = 1'b1;
                     state_d         = S_DROP;
                  end
               end
            end
         end
         S_DROP: begin
            ready_c = 1'b1;
            // The error symbol lasts one symbol period.
            if (strobe_c) err_d = 1'b0;
            if (pkt.pkt_valid && pkt.pkt_eop) begin
               ifg_d   = IFG_LOAD;
               state_d = S_IFG;
            end
         end
         S_IFG: begin
            if (strobe_c) begin
               if (ifg_q == '0) state_d = S_IDLE;
               else             ifg_d   = ifg_q - IFG_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line outputs reflect the state being entered, so they move with the strobe.
      case (state_d)
         S_PRE: begin
            tx_en_d = 1'b1;
            txd_d   = MII_DATA_W'(PRE_WORD >> (32'(idx_d) * MII_DATA_W));
         end
         S_DATA: begin
            tx_en_d = 1'b1;
            txd_d   = MII_DATA_W'(buf_data_d >> (32'(idx_d) * MII_DATA_W));
         end
         S_DROP: begin
            tx_en_d = err_d;
            tx_er_d = err_d;
         end
         default: ;
      endcase

      stat_pkt_done_d = strobe_c && (state_d == S_DATA) && buf_eop_d &&
                        (idx_d == last_sym(buf_eop_d, buf_bytes_d));
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         idx_q           <= '0;
         ifg_q           <= '0;
         div_q           <= '0;
         speed_q         <= 1'b0;
         err_q           <= 1'b0;
         buf_data_q      <= '0;
         buf_eop_q       <= 1'b0;
         buf_bytes_q     <= '0;
         txd_q           <= '0;
         tx_en_q         <= 1'b0;
         tx_er_q         <= 1'b0;
         stat_pkt_done_q <= 1'b0;
         stat_underrun_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         ifg_q           <= ifg_d;
         div_q           <= div_d;
         speed_q         <= speed_d;
         err_q           <= err_d;
         buf_data_q      <= buf_data_d;
         buf_eop_q       <= buf_eop_d;
         buf_bytes_q     <= buf_bytes_d;
         txd_q           <= txd_d;
         tx_en_q         <= tx_en_d;
         tx_er_q         <= tx_er_d;
         stat_pkt_done_q <= stat_pkt_done_d;
         stat_underrun_q <= stat_underrun_d;
      end
   end

   assign txd           = txd_q;
   assign tx_en         = tx_en_q;
   assign tx_er         = tx_er_q;
   assign stat_pkt_done = stat_pkt_done_q;
   assign stat_underrun = stat_underrun_q;
endmodule

// File: tb/tb_peg_l2_rs_xmii_tx.sv
// Directed bench for peg_l2_rs_xmii_tx at PKT_DATA_W=64, MII_DATA_W=2, IFG_BYTES=12, SLOW_DIV=10.
module tb_peg_l2_rs_xmii_tx;
   localparam int LOGN = 1600;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_speed = 1'b1;
   logic [1:0] txd;
   logic       tx_en, tx_er, stat_pkt_done, stat_underrun;

   int n_vec = 0;
   int n_miscmp = 0;

   logic [63:0] w_data  [8];
   logic        w_sop   [8];
   logic        w_eop   [8];
   logic [2:0]  w_bytes [8];

   logic [1:0] l_txd  [LOGN];
   logic       l_en   [LOGN];
   logic       l_er   [LOGN];
   logic       l_done [LOGN];
   logic       l_und  [LOGN];
   logic       l_rdy  [LOGN];

   localparam logic [63:0] W0 = 64'hC123_4567_89AB_CDEF;
   localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;

   peg_l2_rs_xmii_tx_if #(.PKT_DATA_W(64)) pkt_if ();

   peg_l2_rs_xmii_tx #(
      .PKT_DATA_W(64), .MII_DATA_W(2), .IFG_BYTES(12), .SLOW_DIV(10)
   ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .cfg_speed_100_n_10 (cfg_speed),
      .pkt                (pkt_if),
      .txd                (txd),
      .tx_en              (tx_en),
      .tx_er              (tx_er),
      .stat_pkt_done      (stat_pkt_done),
      .stat_underrun      (stat_underrun)
   );

   always #5 clk = ~clk;

   // Expected line symbol k of a packet: 31 preamble dibits 01, SFD tail 11, then data of a then b.
   function automatic logic [1:0] exp_sym(input int k, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] cat;
      cat = {b, a};
      if (k < 31)       return 2'b01;
      else if (k == 31) return 2'b11;
      else              return cat[2*(k-32) +: 2];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pkt_if.pkt_valid = 1'b0;
      pkt_if.pkt_sop   = 1'b0;
      pkt_if.pkt_eop   = 1'b0;
      pkt_if.pkt_bytes = '0;
      pkt_if.pkt_data  = '0;
   endtask

   task automatic do_reset(input logic speed);
      rst       = 1'b1;
      cfg_speed = speed;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Offers the word table to the DUT (first word at once, the rest from cycle gap_at) and logs outputs.
   task automatic run_capture(input int n_words, input int gap_at, input int n_cycles, output int used);
      int   ptr;
      logic fire;
      ptr = 0;
      for (int i = 0; i < n_cycles; i++) begin
         if (ptr < n_words && (ptr == 0 || i >= gap_at)) begin
            pkt_if.pkt_valid = 1'b1;
            pkt_if.pkt_sop   = w_sop[ptr];
            pkt_if.pkt_eop   = w_eop[ptr];
            pkt_if.pkt_bytes = w_bytes[ptr];
            pkt_if.pkt_data  = w_data[ptr];
         end else begin
            idle_inputs();
         end
         #1;
         fire = pkt_if.pkt_valid & pkt_if.pkt_ready;
         @(posedge clk);
         if (fire) ptr++;
         #1;
         l_txd[i]  = txd;
         l_en[i]   = tx_en;
         l_er[i]   = tx_er;
         l_done[i] = stat_pkt_done;
         l_und[i]  = stat_underrun;
         l_rdy[i]  = pkt_if.pkt_ready;
      end
      idle_inputs();
      used = ptr;
   endtask

   task automatic set_word(input int i, input logic [63:0] d, input logic s, input logic e, input logic [2:0] b);
      w_data[i] = d; w_sop[i] = s; w_eop[i] = e; w_bytes[i] = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_speed = 1'b1;
      idle_inputs();
      pkt_if.pkt_valid = 1'b1;
      pkt_if.pkt_sop   = 1'b1;
      #1;
      n_vec++;
      if (pkt_if.pkt_ready !== 1'b0) begin n_miscmp++; $display("FAIL reset_ready: got %b want 0", pkt_if.pkt_ready); end
      tick();
      n_vec++;
      if ({txd, tx_en, tx_er, stat_pkt_done, stat_underrun, pkt_if.pkt_ready} !== 7'b0) begin
         n_miscmp++;
         $display("FAIL reset_outputs: got txd=%b en=%b er=%b done=%b und=%b rdy=%b want all 0",
                  txd, tx_en, tx_er, stat_pkt_done, stat_underrun, pkt_if.pkt_ready);
      end
      tick();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_line_100();
      int used, cnt;
      do_reset(1'b1);
      set_word(0, W0, 1'b1, 1'b0, 3'd0);
      set_word(1, W1, 1'b0, 1'b1, 3'd0);
      run_capture(2, 0, 200, used);
      n_vec++;
      if (used !== 2) begin n_miscmp++; $display("FAIL l100_used: got %0d want 2", used); end
      n_vec++;
      if (l_en[0] !== 1'b1) begin n_miscmp++; $display("FAIL l100_latency: got %b want 1", l_en[0]); end
      cnt = 0;
      for (int i = 0; i < 200; i++) if (l_en[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 96) begin n_miscmp++; $display("FAIL l100_en_len: got %0d want 96", cnt); end
      n_vec++;
      if (l_en[96] !== 1'b0) begin n_miscmp++; $display("FAIL l100_en_fall: got %b want 0", l_en[96]); end
      for (int k = 0; k < 96; k++) begin
         n_vec++;
         if (l_txd[k] !== exp_sym(k, W0, W1)) begin
            n_miscmp++;
            $display("FAIL l100_sym[%0d]: got %b want %b", k, l_txd[k], exp_sym(k, W0, W1));
         end
      end
      cnt = 0;
      for (int i = 0; i < 200; i++) if (l_done[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 1 || l_done[95] !== 1'b1) begin
         n_miscmp++; $display("FAIL l100_done: got count=%0d at95=%b want 1,1", cnt, l_done[95]);
      end
      cnt = 0;
      for (int i = 0; i < 200; i++) if (l_er[i] !== 1'b0 || l_und[i] !== 1'b0) cnt++;
      n_vec++;
      if (cnt !== 0) begin n_miscmp++; $display("FAIL l100_no_err: got %0d err cycles want 0", cnt); end
      cnt = 0;
      for (int i = 96; i < 144; i++) if (l_txd[i] !== 2'b00 || l_rdy[i] !== 1'b0) cnt++;
      n_vec++;
      if (cnt !== 0) begin n_miscmp++; $display("FAIL l100_ifg_quiet: got %0d busy cycles want 0", cnt); end
      n_vec++;
      if (l_rdy[144] !== 1'b1) begin n_miscmp++; $display("FAIL l100_idle_ready: got %b want 1", l_rdy[144]); end
   endtask

   task automatic test_line_10();
      int used, cnt;
      do_reset(1'b0);
      set_word(0, W0, 1'b1, 1'b0, 3'd0);
      set_word(1, W1, 1'b0, 1'b1, 3'd0);
      run_capture(2, 0, 1500, used);
      n_vec++;
      if (l_en[0] !== 1'b1) begin n_miscmp++; $display("FAIL l10_latency: got %b want 1", l_en[0]); end
      cnt = 0;
      for (int i = 0; i < 1500; i++) if (l_en[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 960 || l_en[959] !== 1'b1 || l_en[960] !== 1'b0) begin
         n_miscmp++; $display("FAIL l10_en_len: got %0d want 960", cnt);
      end
      for (int k = 0; k < 96; k++) begin
         n_vec++;
         if (l_txd[10*k] !== exp_sym(k, W0, W1) || l_txd[10*k+9] !== exp_sym(k, W0, W1)) begin
            n_miscmp++;
            $display("FAIL l10_sym[%0d]: got %b..%b want %b", k, l_txd[10*k], l_txd[10*k+9], exp_sym(k, W0, W1));
         end
      end
      cnt = 0;
      for (int i = 0; i < 1500; i++) if (l_done[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 1) begin n_miscmp++; $display("FAIL l10_done: got %0d want 1", cnt); end
      n_vec++;
      if (l_rdy[1439] !== 1'b0 || l_rdy[1440] !== 1'b1) begin
         n_miscmp++; $display("FAIL l10_ifg_end: got %b%b want 01", l_rdy[1439], l_rdy[1440]);
      end
   endtask

   task automatic test_partial();
      int used, cnt;
      do_reset(1'b1);
      set_word(0, W0, 1'b1, 1'b0, 3'd0);
      set_word(1, W1, 1'b0, 1'b1, 3'd3);
      run_capture(2, 0, 150, used);
      cnt = 0;
      for (int i = 0; i < 150; i++) if (l_en[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 76 || l_en[76] !== 1'b0) begin n_miscmp++; $display("FAIL part_en_len: got %0d want 76", cnt); end
      for (int k = 64; k < 76; k++) begin
         n_vec++;
         if (l_txd[k] !== exp_sym(k, W0, W1)) begin
            n_miscmp++;
            $display("FAIL part_sym[%0d]: got %b want %b", k, l_txd[k], exp_sym(k, W0, W1));
         end
      end
      n_vec++;
      if (l_done[75] !== 1'b1 || l_done[74] !== 1'b0) begin
         n_miscmp++; $display("FAIL part_done: got %b%b want 01", l_done[74], l_done[75]);
      end
   endtask

   task automatic test_underrun();
      int used, cnt;
      do_reset(1'b1);
      set_word(0, W0, 1'b1, 1'b0, 3'd0);
      set_word(1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 3'd0);
      set_word(2, W1, 1'b1, 1'b1, 3'd0);
      run_capture(3, 80, 160, used);
      n_vec++;
      if (used !== 3) begin n_miscmp++; $display("FAIL und_used: got %0d want 3", used); end
      n_vec++;
      if (l_en[63] !== 1'b1 || l_txd[63] !== 2'b11) begin
         n_miscmp++; $display("FAIL und_last_data: got en=%b txd=%b want 1,11", l_en[63], l_txd[63]);
      end
      n_vec++;
      if ({l_en[64], l_er[64], l_txd[64], l_und[64]} !== 5'b11001) begin
         n_miscmp++;
         $display("FAIL und_err_sym: got en=%b er=%b txd=%b und=%b want 1,1,00,1", l_en[64], l_er[64], l_txd[64], l_und[64]);
      end
      cnt = 0;
      for (int i = 0; i < 160; i++) if (l_er[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 1) begin n_miscmp++; $display("FAIL und_er_len: got %0d want 1", cnt); end
      cnt = 0;
      for (int i = 0; i < 160; i++) if (l_und[i] === 1'b1 || l_done[i] === 1'b1) cnt++;
      n_vec++;
      if (cnt !== 1) begin n_miscmp++; $display("FAIL und_pulses: got %0d want 1", cnt); end
      cnt = 0;
      for (int i = 65; i < 160; i++) if (l_en[i] !== 1'b0) cnt++;
      n_vec++;
      if (cnt !== 0) begin n_miscmp++; $display("FAIL und_drop_quiet: got %0d en cycles want 0", cnt); end
      cnt = 0;
      for (int i = 64; i < 80; i++) if (l_rdy[i] !== 1'b1) cnt++;
      n_vec++;
      if (cnt !== 0) begin n_miscmp++; $display("FAIL und_drop_ready: got %0d low cycles want 0", cnt); end
      n_vec++;
      if (l_rdy[81] !== 1'b0 || l_rdy[128] !== 1'b0 || l_rdy[129] !== 1'b1) begin
         n_miscmp++; $display("FAIL und_ifg: got %b%b%b want 001", l_rdy[81], l_rdy[128], l_rdy[129]);
      end
   endtask

   task automatic test_back_to_back();
      int used, cnt;
      do_reset(1'b1);
      set_word(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, 3'd0);
      set_word(1, W0, 1'b1, 1'b0, 3'd0);
      set_word(2, W1, 1'b0, 1'b1, 3'd0);
      set_word(3, 64'h3333_3333_3333_3332, 1'b1, 1'b1, 3'd0);
      run_capture(4, 0, 260, used);
      n_vec++;
      if (used !== 4) begin n_miscmp++; $display("FAIL b2b_used: got %0d want 4", used); end
      n_vec++;
      if (l_en[0] !== 1'b0 || l_en[1] !== 1'b1) begin
         n_miscmp++; $display("FAIL b2b_stray: got en0=%b en1=%b want 0,1", l_en[0], l_en[1]);
      end
      n_vec++;
      if (l_txd[33] !== 2'b11) begin n_miscmp++; $display("FAIL b2b_a_first: got %b want 11", l_txd[33]); end
      n_vec++;
      if (l_en[96] !== 1'b1 || l_en[97] !== 1'b0 || l_done[96] !== 1'b1) begin
         n_miscmp++; $display("FAIL b2b_a_end: got en=%b%b done=%b want 10,1", l_en[96], l_en[97], l_done[96]);
      end
      cnt = 0;
      for (int i = 97; i < 146; i++) if (l_en[i] === 1'b0) cnt++;
      n_vec++;
      if (cnt !== 49 || l_en[146] !== 1'b1) begin
         n_miscmp++; $display("FAIL b2b_gap: got %0d low, en146=%b want 49,1", cnt, l_en[146]);
      end
      cnt = 0;
      for (int i = 97; i < 145; i++) if (l_rdy[i] !== 1'b0) cnt++;
      n_vec++;
      if (cnt !== 0 || l_rdy[145] !== 1'b1) begin
         n_miscmp++; $display("FAIL b2b_ifg_ready: got %0d ready cycles, rdy145=%b want 0,1", cnt, l_rdy[145]);
      end
      n_vec++;
      if (l_txd[178] !== 2'b10 || l_done[209] !== 1'b1 || l_en[210] !== 1'b0) begin
         n_miscmp++;
         $display("FAIL b2b_b_pkt: got txd=%b done=%b en=%b want 10,1,0", l_txd[178], l_done[209], l_en[210]);
      end
   endtask

   task automatic test_reset_mid();
      int used;
      do_reset(1'b1);
      set_word(0, W0, 1'b1, 1'b0, 3'd0);
      set_word(1, W1, 1'b0, 1'b1, 3'd0);
      run_capture(2, 0, 45, used);
      rst = 1'b1;
      pkt_if.pkt_valid = 1'b1;
      pkt_if.pkt_sop   = 1'b1;
      pkt_if.pkt_eop   = 1'b1;
      pkt_if.pkt_data  = W1;
      #1;
      n_vec++;
      if (pkt_if.pkt_ready !== 1'b0) begin n_miscmp++; $display("FAIL rmid_ready_in_rst: got %b want 0", pkt_if.pkt_ready); end
      tick();
      n_vec++;
      if ({tx_en, txd, tx_er, pkt_if.pkt_ready} !== 5'b0) begin
         n_miscmp++;
         $display("FAIL rmid_outputs: got en=%b txd=%b er=%b rdy=%b want 0", tx_en, txd, tx_er, pkt_if.pkt_ready);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (pkt_if.pkt_ready !== 1'b1) begin n_miscmp++; $display("FAIL rmid_idle_ready: got %b want 1", pkt_if.pkt_ready); end
      @(posedge clk);
      #1;
      idle_inputs();
      n_vec++;
      if (tx_en !== 1'b1 || txd !== 2'b01) begin
         n_miscmp++; $display("FAIL rmid_restart: got en=%b txd=%b want 1,01", tx_en, txd);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_line_100();
      test_line_10();
      test_partial();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
